// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB update controller: buffers resolved-branch updates and sequences set read/write
//
// Purpose: accepts resolved-branch updates into a 2-entry in-order FIFO, then
// reads the target set, captures it, and issues the write-back, always
// yielding the shared set array to fetch lookups.
// Optional feature: define BTB_UPD_STATS_EN to build the update/stall counters;
// otherwise stat_updates/stat_stalls are tied to 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   fetch_req, fetch_pc           fetch lookup (highest priority array user)
//   upd_valid/upd_ready           update handshake; upd_pc, upd_target, upd_mispredicted
//   arr_en, arr_we, arr_index     set-array control; arr_rdata read data (1-cycle latency)
//   wl_*                          operands for the external set write-back logic
//   busy                          FIFO non-empty or sequencer not idle
//   stat_updates, stat_stalls     saturating statistics counters
module btb_update_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_req,
  input  logic [31:0]  fetch_pc,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [31:0]  upd_pc,
  input  logic [31:0]  upd_target,
  input  logic         upd_mispredicted,
  output logic         arr_en,
  output logic         arr_we,
  output logic [2:0]   arr_index,
  input  logic [127:0] arr_rdata,
  output logic [127:0] wl_old_set,
  output logic [26:0]  wl_new_tag,
  output logic [31:0]  wl_new_target,
  output logic         wl_mispredicted,
  output logic         wl_update_branch1,
  output logic         wl_update_branch2,
  output logic         wl_lru_write,
  output logic         busy,
  output logic [15:0]  stat_updates,
  output logic [15:0]  stat_stalls
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR      = 2'd2;

  logic [1:0]   r_state;
  logic [31:0]  r_fifo_pc  [2];
  logic [31:0]  r_fifo_tgt [2];
  logic         r_fifo_mis [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic [31:0]  r_w_pc;
  logic [31:0]  r_w_tgt;
  logic         r_w_mis;
  logic [127:0] r_old_set;
  logic [7:0]   r_lru;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_write;
  logic [31:0]  w_head_pc;
  logic [2:0]   w_idx;
  logic [26:0]  w_tag;
  logic         w_hit1;
  logic         w_hit2;
  logic         w_lru_bit;
  logic         w_way1_wr;
  logic         w_unused_ok;

  assign w_full    = (r_count == 2'd2);
  assign w_empty   = (r_count == 2'd0);
  assign upd_ready = !w_full;
  assign w_push    = upd_valid && upd_ready;
  // Reset gates every array access the sequencer would otherwise issue, so a
  // reset in WR can never leak a write.
  assign w_pop     = !rst && (r_state == S_IDLE) && !w_empty && !fetch_req;
  assign w_write   = !rst && (r_state == S_WR) && !fetch_req;
  assign w_head_pc = r_fifo_pc[r_rptr];

  assign w_idx     = r_w_pc[4:2];
  assign w_tag     = r_w_pc[31:5];
  assign w_hit1    = r_old_set[127] && (r_old_set[126:100] == w_tag);
  assign w_hit2    = r_old_set[63] && (r_old_set[62:36] == w_tag) && !w_hit1;
  assign w_lru_bit = r_lru[w_idx];
  // Way1 receives the write on a way1 hit, or on a miss when LRU points at way1.
  assign w_way1_wr = w_hit1 || (!w_hit2 && w_lru_bit);

  assign wl_old_set        = r_old_set;
  assign wl_new_tag        = w_tag;
  assign wl_new_target     = r_w_tgt;
  assign wl_mispredicted   = r_w_mis;
  assign wl_update_branch1 = w_hit1;
  assign wl_update_branch2 = w_hit2;
  assign wl_lru_write      = w_lru_bit;
  assign busy              = !w_empty || (r_state != S_IDLE);

  assign w_unused_ok = ^{fetch_pc[31:5], fetch_pc[1:0], r_w_pc[1:0]};

  always_comb begin
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_index = 3'd0;
    if (fetch_req) begin
      arr_en    = 1'b1;
      arr_index = fetch_pc[4:2];
    end else if (w_pop) begin
      arr_en    = 1'b1;
      arr_index = w_head_pc[4:2];
    end else if (w_write) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_index = w_idx;
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]  <= upd_pc;
      r_fifo_tgt[r_wptr] <= upd_target;
      r_fifo_mis[r_wptr] <= upd_mispredicted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_w_pc    <= 32'd0;
      r_w_tgt   <= 32'd0;
      r_w_mis   <= 1'b0;
      r_old_set <= 128'd0;
      r_lru     <= 8'd0;
    end else begin
      if (w_push) r_wptr <= !r_wptr;
      if (w_pop)  r_rptr <= !r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_w_pc  <= w_head_pc;
            r_w_tgt <= r_fifo_tgt[r_rptr];
            r_w_mis <= r_fifo_mis[r_rptr];
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          r_old_set <= arr_rdata;
          r_state   <= S_WR;
        end
        S_WR: begin
          if (w_write) begin
            r_lru[w_idx] <= !w_way1_wr;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BTB_UPD_STATS_EN
  logic [15:0] r_stat_upd;
  logic [15:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = fetch_req && (((r_state == S_IDLE) && !w_empty) || (r_state == S_WR));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_upd   <= 16'd0;
      r_stat_stall <= 16'd0;
    end else begin
      if (w_write && (r_stat_upd != 16'hFFFF))   r_stat_upd   <= r_stat_upd + 16'd1;
      if (w_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_updates = r_stat_upd;
  assign stat_stalls  = r_stat_stall;
`else
  assign stat_updates = 16'd0;
  assign stat_stalls  = 16'd0;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_req;
  logic [31:0]  fetch_pc;
  logic         upd_valid;
  logic         upd_ready;
  logic [31:0]  upd_pc;
  logic [31:0]  upd_target;
  logic         upd_mispredicted;
  logic         arr_en;
  logic         arr_we;
  logic [2:0]   arr_index;
  logic [127:0] arr_rdata;
  logic [127:0] wl_old_set;
  logic [26:0]  wl_new_tag;
  logic [31:0]  wl_new_target;
  logic         wl_mispredicted;
  logic         wl_update_branch1;
  logic         wl_update_branch2;
  logic         wl_lru_write;
  logic         busy;
  logic [15:0]  stat_updates;
  logic [15:0]  stat_stalls;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_mispredicted(upd_mispredicted),
    .arr_en(arr_en), .arr_we(arr_we), .arr_index(arr_index), .arr_rdata(arr_rdata),
    .wl_old_set(wl_old_set), .wl_new_tag(wl_new_tag), .wl_new_target(wl_new_target),
    .wl_mispredicted(wl_mispredicted), .wl_update_branch1(wl_update_branch1),
    .wl_update_branch2(wl_update_branch2), .wl_lru_write(wl_lru_write),
    .busy(busy), .stat_updates(stat_updates), .stat_stalls(stat_stalls)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        mis;
  } upd_t;

  // Environment: set array with 1-cycle read latency, and the write-back
  // logic, which applies each update as the bench expects it to land.
  logic [127:0] mem [8];
  logic         lru_m [8];
  logic [127:0] rd_q = '0;
  upd_t         exp_q [$];
  int           writes_since_rst = 0;

  assign arr_rdata = rd_q;

  always @(posedge clk) if (arr_en && !arr_we) rd_q <= mem[arr_index];

  always @(negedge clk) begin
    upd_t         e;
    logic [127:0] old;
    logic [26:0]  tag;
    logic [2:0]   idx;
    logic         h1, h2, lw;
    logic [193:0] got, want;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++) lru_m[i] = 1'b0;
      writes_since_rst = 0;
    end else begin
      if (fetch_req) begin
        n_cmp++;
        if (!(arr_en === 1'b1 && arr_we === 1'b0 && arr_index === fetch_pc[4:2])) begin
          n_err++;
          $display("FAIL fetch_prio en=%b we=%b idx=%0d want en=1 we=0 idx=%0d",
                   arr_en, arr_we, arr_index, fetch_pc[4:2]);
        end
      end
      if (arr_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write idx=%0d want no write", arr_index);
        end else begin
          e   = exp_q.pop_front();
          idx = e.pc[4:2];
          tag = e.pc[31:5];
          old = mem[idx];
          h1  = old[127] && (old[126:100] == tag);
          h2  = old[63] && (old[62:36] == tag) && !h1;
          lw  = lru_m[idx];
          got  = {arr_index, wl_old_set, wl_new_tag, wl_new_target, wl_mispredicted,
                  wl_update_branch1, wl_update_branch2, wl_lru_write};
          want = {idx, old, tag, e.tgt, e.mis, h1, h2, lw};
          if (got !== want) begin
            n_err++;
            $display("FAIL write_operands got=%h want=%h", got, want);
          end
          if (h1 || (!h2 && lw)) begin
            mem[idx][127] = 1'b1; mem[idx][126:100] = tag; mem[idx][99:68] = e.tgt;
            lru_m[idx] = 1'b0;
          end else begin
            mem[idx][63] = 1'b1; mem[idx][62:36] = tag; mem[idx][35:4] = e.tgt;
            lru_m[idx] = 1'b1;
          end
          writes_since_rst++;
        end
      end
      if (upd_valid && upd_ready) begin
        e.pc = upd_pc; e.tgt = upd_target; e.mis = upd_mispredicted;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = 32'd0; upd_valid = 1'b0;
    upd_pc = 32'd0; upd_target = 32'd0; upd_mispredicted = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if (arr_en !== 1'b0 || arr_we !== 1'b0) begin
      n_err++; $display("FAIL rst_arr_idle en=%b we=%b want 0 0", arr_en, arr_we);
    end
    fetch_req = 1'b1; fetch_pc = 32'h0000_0018;
    @(negedge clk);
    n_cmp++;
    if (arr_en !== 1'b1 || arr_we !== 1'b0 || arr_index !== 3'd6) begin
      n_err++; $display("FAIL rst_fetch en=%b we=%b idx=%0d want 1 0 6", arr_en, arr_we, arr_index);
    end
    tick();
    rst = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (upd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_ready_busy ready=%b busy=%b want 1 0", upd_ready, busy);
    end
    n_cmp++;
    if (stat_updates !== 16'd0 || stat_stalls !== 16'd0) begin
      n_err++; $display("FAIL rst_stats upd=%0d stall=%0d want 0 0", stat_updates, stat_stalls);
    end
    n_cmp++;
    if (wl_old_set !== 128'd0 || wl_new_tag !== 27'd0 || wl_lru_write !== 1'b0) begin
      n_err++; $display("FAIL rst_working old=%h tag=%h lru=%b want 0", wl_old_set, wl_new_tag, wl_lru_write);
    end
    tick();
  endtask

  // Same PC three times into an empty set: miss into way2, then way2 hits.
  task automatic test_insert_and_hit;
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1; upd_pc = 32'h0000_1004; upd_target = 32'h2000 + k;
      upd_mispredicted = k[0];
      @(negedge clk);
      n_cmp++;
      if (upd_ready !== 1'b1) begin
        n_err++; $display("FAIL lat_accept k=%0d ready=%b want 1", k, upd_ready);
      end
      tick();
      upd_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (arr_en !== 1'b1 || arr_we !== 1'b0 || arr_index !== 3'd1) begin
        n_err++; $display("FAIL lat_read k=%0d en=%b we=%b idx=%0d want 1 0 1", k, arr_en, arr_we, arr_index);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (arr_en !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL lat_capture k=%0d en=%b busy=%b want 0 1", k, arr_en, busy);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (arr_we !== 1'b1 || arr_index !== 3'd1 || wl_update_branch1 !== 1'b0 ||
          wl_update_branch2 !== (k > 0) || wl_lru_write !== (k > 0)) begin
        n_err++;
        $display("FAIL lat_write k=%0d we=%b idx=%0d b1=%b b2=%b lru=%b want 1 1 0 %0d %0d",
                 k, arr_we, arr_index, wl_update_branch1, wl_update_branch2, wl_lru_write,
                 int'(k > 0), int'(k > 0));
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (arr_we !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL lat_done k=%0d we=%b busy=%b want 0 0", k, arr_we, busy);
      end
      tick();
    end
  endtask

  task automatic test_both_hit;
    logic [26:0]  tag;
    logic [127:0] s;
    bit           seen;
    tag = 27'h5A5A5A5;
    s = '0;
    s[127] = 1'b1; s[126:100] = tag; s[99:68] = 32'h1111_0000;
    s[63]  = 1'b1; s[62:36]  = tag; s[35:4]  = 32'h2222_0000;
    mem[5] = s;
    upd_valid = 1'b1; upd_pc = {tag, 3'd5, 2'b00}; upd_target = 32'hCAFE_0000; upd_mispredicted = 1'b1;
    tick();
    upd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (arr_we === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (wl_update_branch1 !== 1'b1 || wl_update_branch2 !== 1'b0) begin
          n_err++; $display("FAIL both_hit b1=%b b2=%b want 1 0", wl_update_branch1, wl_update_branch2);
        end
      end
      tick();
    end
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL both_hit_timeout write seen=0 want 1");
    end
  endtask

  task automatic test_fetch_stall;
    logic [15:0] s0;
    int          want;
    upd_valid = 1'b1; upd_pc = 32'h7700_0008; upd_target = 32'h0BAD_0000; upd_mispredicted = 1'b0;
    tick();
    upd_valid = 1'b0;
    tick();
    tick();
    fetch_req = 1'b1;
    @(negedge clk);
    s0 = stat_stalls;
    for (int i = 0; i < 5; i++) begin
      fetch_pc = $urandom;
      @(negedge clk);
      n_cmp++;
      if (arr_we !== 1'b0) begin
        n_err++; $display("FAIL stall_no_write cyc=%0d we=%b want 0", i, arr_we);
      end
      tick();
    end
    fetch_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (arr_we !== 1'b1 || arr_index !== 3'd2) begin
      n_err++; $display("FAIL stall_release we=%b idx=%0d want 1 2", arr_we, arr_index);
    end
`ifdef BTB_UPD_STATS_EN
    want = 5;
`else
    want = 0;
`endif
    n_cmp++;
    if (int'(stat_stalls - s0) !== want) begin
      n_err++; $display("FAIL stall_count got=%0d want=%0d", int'(stat_stalls - s0), want);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs [3];
    bit          want_rdy [5];
    int          sel [5];
    int          base;
    pcs[0] = {$urandom_range(0, 3), 3'd3, 2'b00};
    pcs[1] = {$urandom_range(0, 3), 3'd3, 2'b00};
    pcs[2] = {$urandom_range(0, 3), 3'd0, 2'b00};
    want_rdy = '{1, 1, 0, 0, 1};
    sel = '{0, 1, 2, 2, 2};
    base = writes_since_rst;
    for (int c = 0; c < 5; c++) begin
      fetch_req = (c < 3); fetch_pc = $urandom;
      upd_valid = 1'b1; upd_pc = pcs[sel[c]]; upd_target = $urandom; upd_mispredicted = c[0];
      @(negedge clk);
      n_cmp++;
      if (upd_ready !== want_rdy[c]) begin
        n_err++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", c, upd_ready, want_rdy[c]);
      end
      tick();
    end
    upd_valid = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < 40 && writes_since_rst < base + 3; i++) tick();
    n_cmp++;
    if (writes_since_rst !== base + 3) begin
      n_err++; $display("FAIL b2b_writes got=%0d want=%0d", writes_since_rst - base, 3);
    end
  endtask

  task automatic test_random;
    logic [26:0] tags [3];
    int          want;
    tags[0] = $urandom; tags[1] = $urandom; tags[2] = $urandom;
    for (int c = 0; c < 300; c++) begin
      fetch_req = ($urandom_range(0, 9) < 3); fetch_pc = $urandom;
      upd_valid = $urandom_range(0, 1);
      upd_pc = {tags[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 2'b00};
      upd_target = $urandom; upd_mispredicted = $urandom_range(0, 1);
      tick();
    end
    upd_valid = 1'b0; fetch_req = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || busy); i++) tick();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rand_drain pending=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
`ifdef BTB_UPD_STATS_EN
    want = writes_since_rst;
`else
    want = 0;
`endif
    n_cmp++;
    if (int'(stat_updates) !== want) begin
      n_err++; $display("FAIL rand_stat_updates got=%0d want=%0d", stat_updates, want);
    end
    tick();
  endtask

  task automatic test_reset_midop;
    upd_valid = 1'b1; upd_pc = 32'h1234_5670; upd_target = 32'h1; upd_mispredicted = 1'b0;
    tick();
    upd_pc = 32'h89AB_CDE4;
    tick();
    upd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (arr_we !== 1'b0) begin
      n_err++; $display("FAIL midrst_in_reset we=%b want 0", arr_we);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || upd_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_after busy=%b ready=%b want 0 1", busy, upd_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (arr_we !== 1'b0 || arr_en !== 1'b0) begin
        n_err++; $display("FAIL midrst_quiet cyc=%0d en=%b we=%b want 0 0", i, arr_en, arr_we);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = '0;
      lru_m[i] = 1'b0;
    end
    test_reset();
    test_insert_and_hit();
    test_both_hit();
    test_fetch_stall();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
